fetch_stream_source: RTL

Producer end of the front-end valid/ready stream. Generates sequential fetch PCs and issues reads to a fixed-1-cycle-latency instruction memory. It queues {pc, instr} packets in a DEPTH-entry FIFO and drives them downstream to the decode-side skid buffer. On mispredict it flushes all queued and in-flight work and redirects the PC.

---
 rtl/fetch_stream_source.sv | 89 ++++++++
 1 files changed

// File: rtl/fetch_stream_source.sv
// Fetch-side stream producer: sequential PC generation, 1-cycle instruction memory
// reads, and a DEPTH-entry first-word-fall-through FIFO of {pc, instr} packets.
module fetch_stream_source #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     mispredict,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req_valid,
  output logic [31:0]              imem_req_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     valid_out,
  input  logic                     ready_out,
  output logic [31:0]              pc_out,
  output logic [31:0]              instr_out,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(DEPTH);

  logic [31:0]   pc_q;
  logic          inflight_q;
  logic [31:0]   inflight_pc_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [PW+1:0] occupancy;
  logic          issue;
  logic          push;
  logic          pop;

  // Credit counts the outstanding read as occupied and ignores a same-cycle pop,
  // so a response always has a free slot waiting for it.
  always_comb begin
    occupancy      = {1'b0, count_q} + (PW+2)'(inflight_q);
    issue          = reset_n && !mispredict && (occupancy < DEPTH_W);
    push           = inflight_q && !mispredict;
    valid_out      = (count_q != '0) && !mispredict;
    pop            = valid_out && ready_out;
    imem_req_valid = issue;
    imem_req_addr  = pc_q;
    pc_out         = pc_mem[rd_ptr_q];
    instr_out      = instr_mem[rd_ptr_q];
    fifo_count     = count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (mispredict) begin
      pc_q       <= redirect_pc & ~32'h0000_0003;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 32'd4;
        inflight_pc_q <= pc_q;
      end
      if (push) begin
        pc_mem[wr_ptr_q]    <= inflight_pc_q;
        instr_mem[wr_ptr_q] <= imem_rdata;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule
